// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime baud divisor, 5..DATA_W data bits,
// optional even/odd parity, 1 or 2 stop bits and a DEPTH-entry input FIFO.
module uart_tx_cfg #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int DIV_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic                     tx_valid,
   input  logic [DATA_W-1:0]        tx_data,
   output logic                     tx_ready,
   input  logic [DIV_W-1:0]         cfg_div,
   input  logic [3:0]               cfg_nbits,
   input  logic                     cfg_par_en,
   input  logic                     cfg_par_odd,
   input  logic                     cfg_stop2,
   output logic                     tx_serial,
   output logic                     tx_busy,
   output logic                     tx_done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          bit_idx_q, bit_idx_d;
   logic                stop_idx_q, stop_idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [3:0]          nbits_q, nbits_d;
   logic                par_en_q, par_en_d;
   logic                par_odd_q, par_odd_d;
   logic                stop2_q, stop2_d;
   logic                serial_q, serial_d;
   logic                ready_q, ready_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                push;
   logic                pop;
   logic                bit_end;
   logic                last_stop;
   logic [3:0]          nbits_clamped;

   assign push = tx_valid && ready_q;

   // Config is sampled into the frame registers only at pop time.
   always_comb begin
      if (cfg_nbits < 4'd5) begin
         nbits_clamped = 4'd5;
      end else if (cfg_nbits > 4'(DATA_W)) begin
         nbits_clamped = 4'(DATA_W);
      end else begin
         nbits_clamped = cfg_nbits;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      div_d      = div_q;
      nbits_d    = nbits_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop2_d    = stop2_q;
      pop        = 1'b0;
      last_stop  = 1'b0;

      bit_end = (cnt_q == div_q - DIV_W'(1));
      cnt_d   = bit_end ? '0 : cnt_q + DIV_W'(1);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = 4'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               par_d   = par_q ^ shift_q[0];
               shift_d = shift_q >> 1;
               if (bit_idx_q == nbits_q - 4'd1) begin
                  state_d    = par_en_q ? PARITY : STOP;
                  stop_idx_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_idx_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_idx_q != stop2_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  last_stop = 1'b1;
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         shift_d   = mem_q[rd_ptr_q];
         par_d     = 1'b0;
         div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
         nbits_d   = nbits_clamped;
         par_en_d  = cfg_par_en;
         par_odd_d = cfg_par_odd;
         stop2_d   = cfg_stop2;
      end

      // The line level is derived from the next state so the registered pin
      // changes exactly at bit boundaries.
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         PARITY:  serial_d = par_d ^ par_odd_d;
         default: serial_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      ready_d  = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         div_q      <= DIV_W'(1);
         nbits_q    <= 4'd5;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
         serial_q   <= 1'b1;
         ready_q    <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop
         // samples the values from before this edge, independent of order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         div_q      <= div_d;
         nbits_q    <= nbits_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         stop2_q    <= stop2_d;
         serial_q   <= serial_d;
         ready_q    <= ready_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: the storage array has no reset; resetting the pointers and count
   // already discards its contents, and it maps cleanly onto RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

   assign tx_serial  = serial_q;
   assign tx_ready   = ready_q;
   assign tx_done    = last_stop;
   assign tx_busy    = (state_q != IDLE) || (count_q != '0);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shapes, parity, clamping, FIFO
// back-pressure, config latching and mid-frame reset.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_ready;
   logic [15:0] cfg_div = 16'd4;
   logic [3:0]  cfg_nbits = 4'd8;
   logic        cfg_par_en = 1'b0;
   logic        cfg_par_odd = 1'b0;
   logic        cfg_stop2 = 1'b0;
   logic        tx_serial;
   logic        tx_busy;
   logic        tx_done;
   logic [2:0]  fifo_count;

   int n_cmp = 0;
   int n_mis = 0;

   int acc_edge [6];
   int viol;
   int maxc;
   int e_cnt;
   int w_idx;
   int idle_bad;

   uart_tx_cfg #(.DATA_W(8), .DEPTH(4), .DIV_W(16)) dut (
      .clk        (clk),
      .rst_       (rst_),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .cfg_div    (cfg_div),
      .cfg_nbits  (cfg_nbits),
      .cfg_par_en (cfg_par_en),
      .cfg_par_odd(cfg_par_odd),
      .cfg_stop2  (cfg_stop2),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the word was taken.
   task automatic push(input logic [7:0] w);
      int g;
      @(negedge clk);
      g = 0;
      while (!tx_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("push_ready_seen", 32'(tx_ready), 32'd1);
      tx_valid = 1'b1;
      tx_data  = w;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // exp_bits[i] is the i-th bit on the line (start first), each d clocks long.
   // Called at a negedge; returns at the negedge of the first cycle after the frame.
   task automatic capture_frame(input string tag, input logic [15:0] exp_bits,
                                input int n, input int d, input bit wait_start);
      logic [15:0] cap;
      int unstable;
      int done_cnt;
      int done_at;
      int g;
      logic s;
      cap      = '0;
      unstable = 0;
      done_cnt = 0;
      done_at  = -1;
      if (wait_start) begin
         g = 0;
         while (tx_serial !== 1'b0 && g < 300) begin
            @(negedge clk);
            g++;
         end
         check({tag, "_start_seen"}, 32'(tx_serial == 1'b0), 32'd1);
      end
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < d; c++) begin
            s = tx_serial;
            if (c == 0) cap[b] = s;
            else if (s !== cap[b]) unstable++;
            if (tx_done) begin
               done_cnt++;
               if (done_at < 0) done_at = b * d + c;
            end
            @(negedge clk);
         end
      end
      check({tag, "_bits"}, 32'(cap), 32'(exp_bits));
      check({tag, "_unstable"}, 32'(unstable), 32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_at"}, 32'(done_at), 32'(n * d - 1));
   endtask

   initial begin
      #3 rst_ = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_serial", 32'(tx_serial), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, D=4, latency from accept to start bit
      push(8'hA5);
      check("lat_count_e0", 32'(fifo_count), 32'd1);
      check("lat_busy_e0", 32'(tx_busy), 32'd1);
      check("lat_serial_e0", 32'(tx_serial), 32'd1);
      @(negedge clk);
      check("lat_count_e1", 32'(fifo_count), 32'd0);
      check("lat_serial_e1", 32'(tx_serial), 32'd0);
      capture_frame("a5_8n1", {1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0);
      check("a5_busy_after", 32'(tx_busy), 32'd0);
      check("a5_serial_after", 32'(tx_serial), 32'd1);

      // D=3 with parity
      cfg_div = 16'd3; cfg_par_en = 1'b1; cfg_par_odd = 1'b0;
      push(8'hA5);
      capture_frame("par_even", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 3, 1'b1);
      cfg_par_odd = 1'b1;
      push(8'hA5);
      capture_frame("par_odd", {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 3, 1'b1);

      // 7 data bits, even parity, two stop bits; bit 7 of the word is ignored
      cfg_div = 16'd2; cfg_nbits = 4'd7; cfg_par_odd = 1'b0; cfg_stop2 = 1'b1;
      push(8'hC1);
      capture_frame("n7e2", {2'b11, 1'b0, 7'h41, 1'b0}, 11, 2, 1'b1);

      // nbits clamping
      cfg_par_en = 1'b0; cfg_stop2 = 1'b0; cfg_nbits = 4'd3;
      push(8'hF5);
      capture_frame("clamp_lo", {1'b1, 5'h15, 1'b0}, 7, 2, 1'b1);
      cfg_nbits = 4'd12;
      push(8'h5A);
      capture_frame("clamp_hi", {1'b1, 8'h5A, 1'b0}, 10, 2, 1'b1);

      // FIFO burst: tx_valid held for six words
      cfg_div = 16'd4; cfg_nbits = 4'd8;
      for (int i = 0; i < 6; i++) acc_edge[i] = -1;
      viol = 0; maxc = 0;
      @(negedge clk);
      fork
         begin
            e_cnt = 0;
            w_idx = 1;
            while (w_idx <= 6 && e_cnt < 400) begin
               tx_valid = 1'b1;
               tx_data  = 8'(w_idx);
               if (fifo_count == 3'd4 && tx_ready) viol++;
               if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
               if (tx_ready) begin
                  acc_edge[w_idx-1] = e_cnt;
                  w_idx++;
               end
               @(negedge clk);
               e_cnt++;
            end
            tx_valid = 1'b0;
         end
         begin
            capture_frame("burst1", {1'b1, 8'h01, 1'b0}, 10, 4, 1'b1);
            capture_frame("burst2", {1'b1, 8'h02, 1'b0}, 10, 4, 1'b0);
            capture_frame("burst3", {1'b1, 8'h03, 1'b0}, 10, 4, 1'b0);
            capture_frame("burst4", {1'b1, 8'h04, 1'b0}, 10, 4, 1'b0);
            capture_frame("burst5", {1'b1, 8'h05, 1'b0}, 10, 4, 1'b0);
            capture_frame("burst6", {1'b1, 8'h06, 1'b0}, 10, 4, 1'b0);
         end
      join
      for (int i = 0; i < 5; i++) check($sformatf("burst_acc%0d", i + 1), 32'(acc_edge[i]), 32'(i));
      check("burst_acc6", 32'(acc_edge[5]), 32'd42);
      check("burst_ready_when_full", 32'(viol), 32'd0);
      check("burst_max_count", 32'(maxc), 32'd4);
      check("burst_busy_after", 32'(tx_busy), 32'd0);

      // divisor change mid-frame only affects the next frame
      push(8'h33);
      fork
         begin
            push(8'hCC);
            repeat (10) @(negedge clk);
            cfg_div = 16'd8;
         end
         begin
            capture_frame("div4", {1'b1, 8'h33, 1'b0}, 10, 4, 1'b1);
            capture_frame("div8", {1'b1, 8'hCC, 1'b0}, 10, 8, 1'b0);
         end
      join
      cfg_div = 16'd0;
      push(8'h96);
      capture_frame("div0", {1'b1, 8'h96, 1'b0}, 10, 1, 1'b1);

      // reset in the middle of DATA with two words queued
      cfg_div = 16'd4;
      push(8'h00);
      push(8'h11);
      push(8'h22);
      repeat (3) @(negedge clk);
      check("pre_rst_count", 32'(fifo_count), 32'd2);
      check("pre_rst_serial", 32'(tx_serial), 32'd0);
      rst_ = 1'b0;
      #1;
      check("mid_rst_serial", 32'(tx_serial), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(tx_busy), 32'd0);
      check("mid_rst_ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      rst_ = 1'b1;
      idle_bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
      end
      check("post_rst_idle", 32'(idle_bad), 32'd0);
      push(8'h3C);
      capture_frame("post_rst_frame", {1'b1, 8'h3C, 1'b0}, 10, 4, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
